// File: rtl/seq_divider_16by8_pkg.sv
// Shared types and defaults for the sequential 16/8 restoring divider.
package seq_divider_16by8_pkg;

    localparam int DEF_WIDTH_N = 16;
    localparam int DEF_WIDTH_D = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The counter must hold WIDTH_N itself, hence the +1.
    function automatic int cnt_width(input int width_n);
        return $clog2(width_n + 1);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/seq_divider_16by8_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
// The subtractor is a borrow-ripple chain of full adders computing t + ~{0,d} + 1.
module div_restore_step #(
    parameter int WIDTH_D = 8
) (
    input  logic [WIDTH_D-1:0] rem,
    input  logic               bit_in,
    input  logic [WIDTH_D-1:0] d,
    output logic [WIDTH_D-1:0] rem_next,
    output logic               q_bit
);

    logic [WIDTH_D:0]   w_t;
    logic [WIDTH_D-1:0] w_diff;
    logic [WIDTH_D:0]   w_c;

    assign w_t    = {rem, bit_in};
    assign w_c[0] = 1'b1;

    for (genvar i = 0; i < WIDTH_D; i++) begin : g_sub
        full_adder u_fa (
            .a  (w_t[i]),
            .b  (~d[i]),
            .ci (w_c[i]),
            .s  (w_diff[i]),
            .co (w_c[i+1])
        );
    end

    // Top bit subtracts 0 (inverted to 1): carry-out reduces to t_msb | carry_in.
    // Its sum bit is always 0 when there is no borrow, so it is not kept.
    assign q_bit    = w_t[WIDTH_D] | w_c[WIDTH_D];
    assign rem_next = q_bit ? w_diff : w_t[WIDTH_D-1:0];

endmodule

// File: rtl/seq_divider_16by8.sv
// Sequential unsigned restoring divider, one quotient bit per clock, one operation in flight.
// Result valid WIDTH_N edges after acceptance (next cycle for D==0), held until out_ready.
module seq_divider_16by8
    import seq_divider_16by8_pkg::*;
#(
    parameter int WIDTH_N = DEF_WIDTH_N,
    parameter int WIDTH_D = DEF_WIDTH_D
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH_N-1:0] dividend,
    input  logic [WIDTH_D-1:0] divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH_N-1:0] quotient,
    output logic [WIDTH_D-1:0] remainder,
    output logic               div_by_zero
);

    localparam int CNT_W = cnt_width(WIDTH_N);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH_N-1:0] r_nq;
    logic [WIDTH_D-1:0] r_rem;
    logic [WIDTH_D-1:0] r_d;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_dbz;
    logic               w_accept;
    logic               w_d_zero;
    logic [WIDTH_D-1:0] w_rem_nxt;
    logic               w_q_bit;

    // Gated by rst so the request port reads not-ready while reset is held.
    assign in_ready  = (r_state == ST_IDLE) & ~rst;
    assign out_valid = (r_state == ST_DONE);
    assign w_accept  = in_valid & in_ready;
    assign w_d_zero  = (divisor == '0);

    div_restore_step #(
        .WIDTH_D (WIDTH_D)
    ) u_step (
        .rem      (r_rem),
        .bit_in   (r_nq[WIDTH_N-1]),
        .d        (r_d),
        .rem_next (w_rem_nxt),
        .q_bit    (w_q_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = w_d_zero ? ST_DONE : ST_CALC;
            ST_CALC: if (r_cnt == CNT_W'(1)) w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // r_nq starts as N and ends as Q: dividend bits leave the MSB as quotient bits enter the LSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nq  <= '0;
            r_rem <= '0;
            r_d   <= '0;
            r_cnt <= '0;
            r_dbz <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_d   <= divisor;
                        r_rem <= '0;
                        r_dbz <= w_d_zero;
                        if (w_d_zero) begin
                            r_nq  <= '1;
                            r_cnt <= '0;
                        end else begin
                            r_nq  <= dividend;
                            r_cnt <= CNT_W'(WIDTH_N);
                        end
                    end
                end
                ST_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_nq  <= {r_nq[WIDTH_N-2:0], w_q_bit};
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign quotient    = r_nq;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider_16by8.sv
// Self-checking bench for seq_divider_16by8: directed cases, backpressure, reset abort, random ops.
module tb_seq_divider_16by8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_divider_16by8 dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Presents one request, then counts clock edges after the acceptance edge until out_valid.
    task automatic run_op(input logic [15:0] n, input logic [7:0] d, output int lat,
                          output logic [15:0] q, output logic [7:0] r, output logic z,
                          output bit rdy_low);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1;
        dividend = n;
        divisor  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        lat      = 0;
        rdy_low  = 1'b1;
        while (!out_valid && lat < 40) begin
            if (in_ready) rdy_low = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        q = quotient;
        r = remainder;
        z = div_by_zero;
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== 27'd0) begin
            errors++;
            $display("FAIL reset_state rdy=%b vld=%b q=%h r=%h dbz=%b, want all 0",
                     in_ready, out_valid, quotient, remainder, div_by_zero);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_rdy_held got %b want 0", in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_rdy_release got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [15:0] tn [4] = '{16'd65025, 16'd1000, 16'hFFFF, 16'd5};
        logic [7:0]  td [4] = '{8'd255, 8'd7, 8'd1, 8'd200};
        logic [15:0] tq [4] = '{16'd255, 16'd142, 16'hFFFF, 16'd0};
        logic [7:0]  tr [4] = '{8'd0, 8'd6, 8'd0, 8'd5};
        int lat;
        logic [15:0] q;
        logic [7:0] r;
        logic z;
        bit rl;
        for (int i = 0; i < 4; i++) begin
            run_op(tn[i], td[i], lat, q, r, z, rl);
            checks++;
            if (q !== tq[i] || r !== tr[i] || z !== 1'b0) begin
                errors++;
                $display("FAIL directed_%0d got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=0",
                         i, q, r, z, tq[i], tr[i]);
            end
            checks++;
            if (lat != 16) begin
                errors++;
                $display("FAIL directed_latency_%0d got %0d want 16", i, lat);
            end
            checks++;
            if (!rl) begin
                errors++;
                $display("FAIL directed_rdy_busy_%0d in_ready high during CALC, want 0", i);
            end
            ack();
        end
    endtask

    task automatic test_div_zero();
        int lat;
        logic [15:0] q;
        logic [7:0] r;
        logic z;
        bit rl;
        run_op(16'h1234, 8'd0, lat, q, r, z, rl);
        checks++;
        if (q !== 16'hFFFF || r !== 8'd0 || z !== 1'b1 || lat != 0) begin
            errors++;
            $display("FAIL div_zero got q=%h r=%0d dbz=%b lat=%0d want q=ffff r=0 dbz=1 lat=0",
                     q, r, z, lat);
        end
        ack();
        checks++;
        if (div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL div_zero_hold_idle got %b want 1", div_by_zero);
        end
        run_op(16'd50, 8'd7, lat, q, r, z, rl);
        checks++;
        if (q !== 16'd7 || r !== 8'd1 || z !== 1'b0) begin
            errors++;
            $display("FAIL div_zero_clear got q=%0d r=%0d dbz=%b want q=7 r=1 dbz=0", q, r, z);
        end
        ack();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [15:0] q;
        logic [7:0] r;
        logic z;
        bit rl;
        bit bad = 1'b0;
        run_op(16'd1000, 8'd7, lat, q, r, z, rl);
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 16'd300;
        divisor  = 8'd10;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || quotient !== 16'd142 || remainder !== 8'd6 || in_ready !== 1'b0)
                bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bp_hold got vld=%b q=%0d r=%0d rdy=%b want vld=1 q=142 r=6 rdy=0",
                     out_valid, quotient, remainder, in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_after_handshake got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_pending_accept got rdy=%b want 0", in_ready);
        end
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (quotient !== 16'd30 || remainder !== 8'd0 || lat != 16) begin
            errors++;
            $display("FAIL bp_pending_result got q=%0d r=%0d lat=%0d want q=30 r=0 lat=16",
                     quotient, remainder, lat);
        end
        ack();
    endtask

    task automatic test_rst_mid_calc();
        int lat;
        logic [15:0] q;
        logic [7:0] r;
        logic z;
        bit rl;
        bit seen = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 16'd40000;
        divisor  = 8'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_calc got vld=%b rdy=%b want 0 0", out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_release_rdy got %b want 1", in_ready);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rst_discard out_valid rose for aborted op, want never");
        end
        run_op(16'd100, 8'd3, lat, q, r, z, rl);
        checks++;
        if (q !== 16'd33 || r !== 8'd1) begin
            errors++;
            $display("FAIL rst_next_op got q=%0d r=%0d want q=33 r=1", q, r);
        end
        ack();
    endtask

    task automatic test_random();
        int lat;
        int exp_lat;
        logic [15:0] q;
        logic [7:0] r;
        logic z;
        bit rl;
        int a;
        int b;
        int n;
        int d;
        int eq;
        int er;
        bit ez;
        for (int i = 0; i < 2300; i++) begin
            if (i < 2000) begin
                a = int'($urandom_range(0, 255));
                b = int'($urandom_range(1, 255));
                n = a * b;
                d = b;
            end else begin
                n = int'($urandom_range(0, 65535));
                d = (i % 50 == 0) ? 0 : int'($urandom_range(0, 255));
            end
            if (d == 0) begin
                eq = 65535;
                er = 0;
                ez = 1'b1;
            end else begin
                eq = n / d;
                er = n % d;
                ez = 1'b0;
            end
            exp_lat = (d == 0) ? 0 : 16;
            run_op(16'(n), 8'(d), lat, q, r, z, rl);
            checks++;
            if (int'(q) != eq || int'(r) != er || z !== ez || lat != exp_lat) begin
                errors++;
                $display("FAIL random_%0d n=%0d d=%0d got q=%0d r=%0d dbz=%b lat=%0d want q=%0d r=%0d dbz=%b lat=%0d",
                         i, n, d, q, r, z, lat, eq, er, ez, exp_lat);
            end
            ack();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_backpressure();
        test_rst_mid_calc();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
